cache_rd_arbiter: RTL and testbench
===================================

# cache_rd_arbiter

Shares one memory-side cache read port between `NREQ` cache clients (client 0 = icache, client 1 = dcache by default). Each client uses the same read handshake as the cache miss path: `rd_req`/`rd_rdy` request, then `ret_valid`/`ret_last`/`ret_data` return. The block sits between the caches and the AXI bridge. It grants one read transaction at a time, forwards the granted request and steers the returned beats back to the owner.

## Interface
- `NREQ`, 2, number of requesting clients (2..8)
- `clk` in 1, sole clock, rising edge
- `reset` in 1, synchronous, active-high
- `req_rd_req` in NREQ, per-client read request; held until its `req_rd_rdy` bit
- `req_rd_type` in 3*NREQ, per-client type; 3'b000/001/010 = byte/half/word, 3'b100 = line (4 beats)
- `req_rd_addr` in 32*NREQ, per-client address; held with `req_rd_req`
- `req_rd_rdy` out NREQ, request accepted, one-hot or zero
- `req_ret_valid` out NREQ, return beat valid, one-hot or zero
- `req_ret_last` out NREQ, last return beat, one-hot or zero
- `req_ret_data` out 32, return data, broadcast to all clients
- `mem_rd_req` out 1, request to bridge
- `mem_rd_type` out 3, type of the granted request
- `mem_rd_addr` out 32, address of the granted request
- `mem_rd_rdy` in 1, bridge accepts the request
- `mem_ret_valid` in 1, bridge return beat
- `mem_ret_last` in 1, bridge last beat
- `mem_ret_data` in 32, bridge data

## Operation
- States: IDLE, ISSUE, RESP.
- Arbitration happens in IDLE, and in RESP on the cycle with `mem_ret_valid & mem_ret_last`.
  - If any `req_rd_req` bit is set, the block latches the winner index into `grant` and latches that client's type and address into `type_q`/`addr_q`, then goes to ISSUE.
  - With no requests, it goes to (or stays in) IDLE.
- ISSUE:
  - `mem_rd_req`=1, `mem_rd_type`=`type_q`, `mem_rd_addr`=`addr_q`.
  - `req_rd_rdy[grant]` = `mem_rd_rdy` (combinational).
  - When `mem_rd_rdy`=1, go to RESP. Otherwise hold.
- RESP:
  - `req_ret_valid[grant]` = `mem_ret_valid`.
  - `req_ret_last[grant]` = `mem_ret_valid & mem_ret_last`.
  - `req_ret_data` = `mem_ret_data` in every state.
  - The transaction ends only on a `ret_last` beat, regardless of type or beat count.
- `mem_ret_valid` outside RESP is ignored and never forwarded.
- Non-granted clients see 0 on `rdy`, `ret_valid` and `ret_last` at all times.
- If a client deasserts `req_rd_req` after being granted, the latched request is still issued. Clients must not do this.

## Timing
- Reset values:
  - state IDLE; `grant`, `type_q`, `addr_q` = 0; round-robin pointer = 0.
  - All outputs 0 except `req_ret_data`, which follows `mem_ret_data`.
- Latency from request to `mem_rd_req`: 1 cycle (IDLE sample, ISSUE next cycle).
- Back-to-back transactions: zero bubble. On a last beat with a pending request, ISSUE follows in the next cycle.
- Acceptance: `req_rd_rdy` and `mem_rd_rdy` fall in the same cycle.
- Return path is purely combinational; it adds no cycles.
- Reset asserted mid-transaction: the block returns to IDLE next cycle and drops the in-flight transaction. Stale beats arriving afterwards are discarded.
- Only one transaction is outstanding at a time.

## Configuration
- `CACHE_ARB_RR_EN` defined: round-robin arbitration.
  - The pointer is updated to `grant+1` (mod NREQ) on each ISSUE-to-RESP transition.
  - The winner is the first requester at or after the pointer, wrapping around.
- Macro undefined: fixed priority. The highest index wins, so by default dcache beats icache. The pointer is not implemented.

## Structure
- Shared package `cache_pkg`:
  - state encodings `ARB_IDLE`/`ARB_ISSUE`/`ARB_RESP` (one-hot, 3 bits)
  - `RD_TYPE_LINE` = 3'b100
  - `RD_TYPE_WORD` = 3'b010
- One sub-module, `arb_pick`: combinational winner selection from the request vector and pointer, plus a valid output. It contains both macro variants.
- The top holds the FSM, the latches and the steering logic.

## Test plan
- Single icache line read, addr 0x1c00_0040: `mem_rd_req` with type 3'b100 one cycle after the request. Four beats 0xA0..0xA3 appear on `req_ret_valid[0]`, and `req_ret_last[0]` is set on 0xA3. `req_*[1]` stays 0.
- Both clients request in the same cycle:
  - fixed priority: dcache is issued first, icache issues the cycle after dcache's last beat.
  - `CACHE_ARB_RR_EN`: order alternates across 4 repeated rounds (1,0,1,0).
- `mem_rd_rdy` held low for 5 cycles in ISSUE: `mem_rd_req` and `mem_rd_addr` stay stable. `req_rd_rdy` pulses only in the accept cycle.
- Stray `mem_ret_valid` with data 0xDEAD in IDLE: no `req_ret_valid` bit asserts.
- Reset asserted during the 2nd beat of a line return: next cycle all outputs are 0 and the state is IDLE. A new dcache word read (type 3'b010) completes with one beat.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache read-port arbiter: FSM encodings, read types
// and a small modular-increment helper.
package cache_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'b001,
        ARB_ISSUE = 3'b010,
        ARB_RESP  = 3'b100
    } arb_state_e;

    localparam logic [2:0] RD_TYPE_LINE = 3'b100;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection. CACHE_ARB_RR_EN selects round-robin from ptr_i;
// otherwise fixed priority with the highest index winning.
module arb_pick #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
`ifdef CACHE_ARB_RR_EN
    input  logic [PW-1:0]   ptr_i,
`endif
    output logic [PW-1:0]   idx_o,
    output logic            valid_o
);

`ifdef CACHE_ARB_RR_EN
    int j;
`endif

    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
`ifdef CACHE_ARB_RR_EN
        j = 0;
        // Scan from farthest to nearest so the first requester at/after ptr_i wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req_i[j]) idx_o = PW'(j);
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (req_i[i]) idx_o = PW'(i);
        end
`endif
    end

endmodule

// File: rtl/cache_rd_arbiter.sv
// Shares one memory-side read port among NREQ cache clients, one transaction at a time.
// Define CACHE_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module cache_rd_arbiter
    import cache_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_rd_req,
    input  logic [3*NREQ-1:0]    req_rd_type,
    input  logic [32*NREQ-1:0]   req_rd_addr,
    output logic [NREQ-1:0]      req_rd_rdy,
    output logic [NREQ-1:0]      req_ret_valid,
    output logic [NREQ-1:0]      req_ret_last,
    output logic [31:0]          req_ret_data,
    output logic                 mem_rd_req,
    output logic [2:0]           mem_rd_type,
    output logic [31:0]          mem_rd_addr,
    input  logic                 mem_rd_rdy,
    input  logic                 mem_ret_valid,
    input  logic                 mem_ret_last,
    input  logic [31:0]          mem_ret_data,
    output logic [2:0]           dbg_state_o
);

    localparam int PW = $clog2(NREQ);

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     grant_q, grant_d;
    logic [2:0]        type_q, type_d;
    logic [31:0]       addr_q, addr_d;
    logic [PW-1:0]     pick_idx;
    logic              pick_valid;
    logic              arb_now;
    logic [2:0]        sel_type;
    logic [31:0]       sel_addr;
    logic [NREQ-1:0]   grant_oh;

`ifdef CACHE_ARB_RR_EN
    logic [PW-1:0]     ptr_q, ptr_d;
`endif

    arb_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_i   (req_rd_req),
`ifdef CACHE_ARB_RR_EN
        .ptr_i   (ptr_q),
`endif
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        sel_type = '0;
        sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == pick_idx) begin
                sel_type = req_rd_type[i*3 +: 3];
                sel_addr = req_rd_addr[i*32 +: 32];
            end
        end
    end

    // Re-arbitrate on the final return beat so a pending request issues with no bubble.
    assign arb_now = (state_q == ARB_IDLE) ||
                     (state_q == ARB_RESP && mem_ret_valid && mem_ret_last);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        type_d  = type_q;
        addr_d  = addr_q;
`ifdef CACHE_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        if (arb_now) begin
            if (pick_valid) begin
                grant_d = pick_idx;
                type_d  = sel_type;
                addr_d  = sel_addr;
                state_d = ARB_ISSUE;
            end else begin
                state_d = ARB_IDLE;
            end
        end else if (state_q == ARB_ISSUE && mem_rd_rdy) begin
            state_d = ARB_RESP;
`ifdef CACHE_ARB_RR_EN
            ptr_d   = PW'(wrap_inc(int'(grant_q), NREQ));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            type_q  <= '0;
            addr_q  <= '0;
`ifdef CACHE_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
`ifdef CACHE_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign grant_oh      = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
    assign mem_rd_req    = (state_q == ARB_ISSUE);
    assign mem_rd_type   = mem_rd_req ? type_q : 3'b000;
    assign mem_rd_addr   = mem_rd_req ? addr_q : 32'h0;
    assign req_rd_rdy    = (mem_rd_req && mem_rd_rdy) ? grant_oh : '0;
    assign req_ret_valid = (state_q == ARB_RESP && mem_ret_valid) ? grant_oh : '0;
    assign req_ret_last  = (state_q == ARB_RESP && mem_ret_valid && mem_ret_last) ? grant_oh : '0;
    assign req_ret_data  = mem_ret_data;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Directed bench for cache_rd_arbiter: vector table for a line read plus sequences
// for arbitration order, ISSUE stall and mid-transaction reset.
module tb_cache_rd_arbiter;

    localparam logic [31:0] A0_LINE = 32'h1c00_0040;
    localparam logic [31:0] A0_ARB  = 32'h1c00_1000;
    localparam logic [31:0] A1_ARB  = 32'h2000_2000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_rd_req;
    logic [2:0]  t0, t1;
    logic [31:0] a0, a1;
    logic [1:0]  req_rd_rdy, req_ret_valid, req_ret_last;
    logic [31:0] req_ret_data;
    logic        mem_rd_req;
    logic [2:0]  mem_rd_type;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_rdy, mem_ret_valid, mem_ret_last;
    logic [31:0] mem_ret_data;
    logic [2:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_rd_arbiter #(.NREQ(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_rd_req    (req_rd_req),
        .req_rd_type   ({t1, t0}),
        .req_rd_addr   ({a1, a0}),
        .req_rd_rdy    (req_rd_rdy),
        .req_ret_valid (req_ret_valid),
        .req_ret_last  (req_ret_last),
        .req_ret_data  (req_ret_data),
        .mem_rd_req    (mem_rd_req),
        .mem_rd_type   (mem_rd_type),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_rdy    (mem_rd_rdy),
        .mem_ret_valid (mem_ret_valid),
        .mem_ret_last  (mem_ret_last),
        .mem_ret_data  (mem_ret_data),
        .dbg_state_o   (dbg_state)
    );

    typedef struct {
        logic [1:0]  req;
        logic        mrdy, mrv, mrl;
        logic [31:0] mdata;
        logic        e_mreq;
        logic [2:0]  e_mtype;
        logic [31:0] e_maddr;
        logic [1:0]  e_rdy, e_rv, e_rl;
    } vec_t;

    vec_t vt[11];

    function automatic vec_t mk(logic [1:0] req, logic mrdy, logic mrv, logic mrl,
                                logic [31:0] mdata, logic e_mreq, logic [2:0] e_mtype,
                                logic [31:0] e_maddr, logic [1:0] e_rdy, logic [1:0] e_rv,
                                logic [1:0] e_rl);
        vec_t v;
        v.req = req; v.mrdy = mrdy; v.mrv = mrv; v.mrl = mrl; v.mdata = mdata;
        v.e_mreq = e_mreq; v.e_mtype = e_mtype; v.e_maddr = e_maddr;
        v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_rl = e_rl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepted transaction for client exp with a single last beat.
    task automatic run_grant(input int exp, input logic [1:0] req_after, input bit immediate);
        int n;
        n = 0;
        #1;
        if (immediate) chk("zero_bubble_issue", {31'b0, mem_rd_req}, 32'd1);
        while (!mem_rd_req && n < 10) begin
            tick();
            #1;
            n++;
        end
        chk("grant_wait_bound", {31'b0, mem_rd_req}, 32'd1);
        chk("grant_addr", mem_rd_addr, (exp == 1) ? A1_ARB : A0_ARB);
        mem_rd_rdy = 1'b1;
        #1;
        chk("grant_rdy", {30'b0, req_rd_rdy}, 32'(1 << exp));
        tick();
        mem_rd_rdy    = 1'b0;
        req_rd_req    = req_after;
        mem_ret_valid = 1'b1;
        mem_ret_last  = 1'b1;
        mem_ret_data  = 32'hB0 + 32'(exp);
        #1;
        chk("grant_ret_valid", {30'b0, req_ret_valid}, 32'(1 << exp));
        chk("grant_ret_last", {30'b0, req_ret_last}, 32'(1 << exp));
        tick();
        mem_ret_valid = 1'b0;
        mem_ret_last  = 1'b0;
    endtask

    int order[4];

    initial begin
        reset = 1'b1;
        req_rd_req = '0; t0 = '0; t1 = '0; a0 = '0; a1 = '0;
        mem_rd_rdy = 1'b0; mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = 32'h55;

        // Single icache line read, then a stray beat and a stray rdy in IDLE.
        vt[0]  = mk(2'b00, 0, 0, 0, 32'h55,   0, 3'b000, 32'h0,   2'b00, 2'b00, 2'b00);
        vt[1]  = mk(2'b01, 0, 0, 0, 32'h0,    0, 3'b000, 32'h0,   2'b00, 2'b00, 2'b00);
        vt[2]  = mk(2'b01, 0, 0, 0, 32'h0,    1, 3'b100, A0_LINE, 2'b00, 2'b00, 2'b00);
        vt[3]  = mk(2'b01, 1, 0, 0, 32'h0,    1, 3'b100, A0_LINE, 2'b01, 2'b00, 2'b00);
        vt[4]  = mk(2'b00, 0, 1, 0, 32'hA0,   0, 3'b000, 32'h0,   2'b00, 2'b01, 2'b00);
        vt[5]  = mk(2'b00, 0, 1, 0, 32'hA1,   0, 3'b000, 32'h0,   2'b00, 2'b01, 2'b00);
        vt[6]  = mk(2'b00, 0, 0, 0, 32'h0,    0, 3'b000, 32'h0,   2'b00, 2'b00, 2'b00);
        vt[7]  = mk(2'b00, 0, 1, 0, 32'hA2,   0, 3'b000, 32'h0,   2'b00, 2'b01, 2'b00);
        vt[8]  = mk(2'b00, 0, 1, 1, 32'hA3,   0, 3'b000, 32'h0,   2'b00, 2'b01, 2'b01);
        vt[9]  = mk(2'b00, 0, 1, 1, 32'hDEAD, 0, 3'b000, 32'h0,   2'b00, 2'b00, 2'b00);
        vt[10] = mk(2'b00, 1, 0, 0, 32'h0,    0, 3'b000, 32'h0,   2'b00, 2'b00, 2'b00);

`ifdef CACHE_ARB_RR_EN
        order = '{1, 0, 1, 0};
`else
        order = '{1, 1, 1, 1};
`endif

        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("reset_state", {29'b0, dbg_state}, 32'h1);

        t0 = 3'b100; a0 = A0_LINE;
        for (int i = 0; i < 11; i++) begin
            req_rd_req    = vt[i].req;
            mem_rd_rdy    = vt[i].mrdy;
            mem_ret_valid = vt[i].mrv;
            mem_ret_last  = vt[i].mrl;
            mem_ret_data  = vt[i].mdata;
            #1;
            chk($sformatf("v%0d_mem_rd_req", i), {31'b0, mem_rd_req}, {31'b0, vt[i].e_mreq});
            if (vt[i].e_mreq || i == 0) begin
                chk($sformatf("v%0d_mem_rd_type", i), {29'b0, mem_rd_type}, {29'b0, vt[i].e_mtype});
                chk($sformatf("v%0d_mem_rd_addr", i), mem_rd_addr, vt[i].e_maddr);
            end
            chk($sformatf("v%0d_req_rd_rdy", i), {30'b0, req_rd_rdy}, {30'b0, vt[i].e_rdy});
            chk($sformatf("v%0d_ret_valid", i), {30'b0, req_ret_valid}, {30'b0, vt[i].e_rv});
            chk($sformatf("v%0d_ret_last", i), {30'b0, req_ret_last}, {30'b0, vt[i].e_rl});
            chk($sformatf("v%0d_ret_data", i), req_ret_data, vt[i].mdata);
            tick();
        end
        mem_rd_rdy = 1'b0; mem_ret_valid = 1'b0; mem_ret_last = 1'b0;

        // Simultaneous requests, each client drops its request once accepted.
        t0 = 3'b010; t1 = 3'b010; a0 = A0_ARB; a1 = A1_ARB;
        req_rd_req = 2'b11;
        run_grant(1, 2'b01, 1'b0);
        run_grant(0, 2'b00, 1'b1);
        #1;
        chk("simul_back_idle", {29'b0, dbg_state}, 32'h1);

        // Both clients keep requesting for four grants.
        req_rd_req = 2'b11;
        run_grant(order[0], 2'b11, 1'b0);
        run_grant(order[1], 2'b11, 1'b1);
        run_grant(order[2], 2'b11, 1'b1);
        run_grant(order[3], 2'b00, 1'b1);
        #1;
        chk("rounds_back_idle", {29'b0, dbg_state}, 32'h1);

        // ISSUE stalled for 5 cycles: request stays stable, rdy only on accept.
        req_rd_req = 2'b01; a0 = 32'h1000_0004; t0 = 3'b010;
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_mem_rd_req", {31'b0, mem_rd_req}, 32'd1);
            chk("stall_mem_rd_addr", mem_rd_addr, 32'h1000_0004);
            chk("stall_req_rd_rdy", {30'b0, req_rd_rdy}, 32'd0);
            tick();
        end
        mem_rd_rdy = 1'b1;
        #1;
        chk("stall_accept_rdy", {30'b0, req_rd_rdy}, 32'd1);
        tick();
        mem_rd_rdy = 1'b0; req_rd_req = 2'b00;
        #1;
        chk("stall_rdy_after", {30'b0, req_rd_rdy}, 32'd0);
        chk("stall_req_after", {31'b0, mem_rd_req}, 32'd0);
        mem_ret_valid = 1'b1; mem_ret_last = 1'b1; mem_ret_data = 32'h77;
        tick();
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0;

        // Reset during the 2nd beat of a line return, then a dcache word read.
        req_rd_req = 2'b01; t0 = 3'b100; a0 = 32'h1c00_0080;
        tick();
        mem_rd_rdy = 1'b1;
        tick();
        mem_rd_rdy = 1'b0; req_rd_req = 2'b00;
        mem_ret_valid = 1'b1; mem_ret_data = 32'hC0;
        #1;
        chk("rst_beat0_valid", {30'b0, req_ret_valid}, 32'd1);
        tick();
        mem_ret_data = 32'hC1; reset = 1'b1;
        tick();
        reset = 1'b0; mem_ret_data = 32'hC2;
        #1;
        chk("rst_state_idle", {29'b0, dbg_state}, 32'h1);
        chk("rst_ret_valid", {30'b0, req_ret_valid}, 32'd0);
        chk("rst_ret_last", {30'b0, req_ret_last}, 32'd0);
        chk("rst_mem_rd_req", {31'b0, mem_rd_req}, 32'd0);
        chk("rst_mem_rd_addr", mem_rd_addr, 32'd0);
        chk("rst_req_rd_rdy", {30'b0, req_rd_rdy}, 32'd0);
        tick();
        mem_ret_data = 32'hC3; mem_ret_last = 1'b1;
        #1;
        chk("rst_stale_last", {30'b0, req_ret_last}, 32'd0);
        tick();
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
        req_rd_req = 2'b10; t1 = 3'b010; a1 = 32'h2000_0008;
        tick();
        #1;
        chk("word_mem_rd_req", {31'b0, mem_rd_req}, 32'd1);
        chk("word_mem_rd_type", {29'b0, mem_rd_type}, 32'h2);
        chk("word_mem_rd_addr", mem_rd_addr, 32'h2000_0008);
        mem_rd_rdy = 1'b1;
        #1;
        chk("word_rdy", {30'b0, req_rd_rdy}, 32'h2);
        tick();
        mem_rd_rdy = 1'b0; req_rd_req = 2'b00;
        mem_ret_valid = 1'b1; mem_ret_last = 1'b1; mem_ret_data = 32'hD0;
        #1;
        chk("word_ret_valid", {30'b0, req_ret_valid}, 32'h2);
        chk("word_ret_last", {30'b0, req_ret_last}, 32'h2);
        chk("word_ret_data", req_ret_data, 32'hD0);
        tick();
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
        #1;
        chk("word_back_idle", {29'b0, dbg_state}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
